// File: rtl/song_pkg.sv
// song_pkg: shared widths, song-entry field positions and the reader FSM
// state type for the song_reader slice.
//
// Song entry layout (ENTRY_W bits):
//   bit ADV_BIT = 0 : note entry    -> FIELD_A = note number, FIELD_B = duration
//   bit ADV_BIT = 1 : advance entry -> FIELD_A = beats to wait, rest ignored
package song_pkg;

    localparam int ENTRY_W    = 16;
    localparam int ADV_BIT    = 15;
    localparam int FIELD_A_HI = 14;
    localparam int FIELD_A_LO = 9;
    localparam int FIELD_B_HI = 8;
    localparam int FIELD_B_LO = 3;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int SONG_W = 2;
    localparam int IDX_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ROMWAIT,
        ST_DECODE,
        ST_WAIT,
        ST_DONE
    } reader_state_e;

    function automatic logic entry_is_advance(input logic [ENTRY_W-1:0] e);
        return e[ADV_BIT];
    endfunction

    function automatic logic [NOTE_W-1:0] entry_field_a(input logic [ENTRY_W-1:0] e);
        return e[FIELD_A_HI:FIELD_A_LO];
    endfunction

    function automatic logic [DUR_W-1:0] entry_field_b(input logic [ENTRY_W-1:0] e);
        return e[FIELD_B_HI:FIELD_B_LO];
    endfunction

endpackage

// File: rtl/note_dispatch_rr.sv
// note_dispatch_rr: hands decoded notes to the note players in round-robin
// order. Owns the player pointer and the registered one-hot load strobe.
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   load_en_i      1 = dispatch note_i/dur_i to the current player this cycle
//   note_i, dur_i  decoded note fields
//   load_player_o  one-hot, 1-cycle load pulse (registered)
//   note_o, dur_o  registered note fields, valid while load_player_o != 0
module note_dispatch_rr
    import song_pkg::*;
#(
    parameter int NUM_PLAYERS = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_en_i,
    input  logic [NOTE_W-1:0]      note_i,
    input  logic [DUR_W-1:0]       dur_i,
    output logic [NUM_PLAYERS-1:0] load_player_o,
    output logic [NOTE_W-1:0]      note_o,
    output logic [DUR_W-1:0]       dur_o
);

    localparam int PTR_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_PLAYERS - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [NUM_PLAYERS-1:0] load_q, load_d;
    logic [NOTE_W-1:0]      note_q, note_d;
    logic [DUR_W-1:0]       dur_q, dur_d;

    always_comb begin
        ptr_d  = ptr_q;
        load_d = '0;
        note_d = note_q;
        dur_d  = dur_q;
        if (load_en_i) begin
            load_d[ptr_q] = 1'b1;
            ptr_d         = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_ONE;
            note_d        = note_i;
            dur_d         = dur_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q  <= '0;
            load_q <= '0;
            note_q <= '0;
            dur_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            load_q <= load_d;
            note_q <= note_d;
            dur_q  <= dur_d;
        end
    end

    assign load_player_o = load_q;
    assign note_o        = note_q;
    assign dur_o         = dur_q;

endmodule

// File: rtl/song_reader.sv
// song_reader: walks the entries of the selected song in the song ROM
// (synchronous read, 1-cycle latency) and drives the note players.
// Note entries are dispatched round-robin to the players; advance entries
// hold the read pointer for a number of beats.
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-high reset
//   play          level: 1 = run, 0 = pause (everything freezes)
//   song          song select (high bits of the ROM address)
//   beat          one-cycle tick per beat
//   rom_dout      song ROM data, valid one cycle after rom_addr changes
//   rom_addr      {cur_song, idx}, driven straight from registers
//   note_out      note number, valid while load_player != 0
//   duration_out  note duration in beats, valid with note_out
//   load_player   one-hot 1-cycle load pulse per player
//   song_done     1-cycle pulse after the last entry completes
//
// Build option SONG_READER_LOOP_EN:
//   defined   -> DONE restarts the song at idx 0 on the next running cycle
//   undefined -> DONE holds until the song changes or play rises 0->1
module song_reader
    import song_pkg::*;
#(
    parameter int NUM_PLAYERS = 3,
    parameter int SONG_LEN    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      play,
    input  logic [SONG_W-1:0]         song,
    input  logic                      beat,
    input  logic [ENTRY_W-1:0]        rom_dout,
    output logic [SONG_W+IDX_W-1:0]   rom_addr,
    output logic [NOTE_W-1:0]         note_out,
    output logic [DUR_W-1:0]          duration_out,
    output logic [NUM_PLAYERS-1:0]    load_player,
    output logic                      song_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [DUR_W-1:0] CNT_ONE  = DUR_W'(1);

    reader_state_e     state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SONG_W-1:0] cur_song_q, cur_song_d;
    logic [DUR_W-1:0]  bcnt_q, bcnt_d;
    logic [NOTE_W-1:0] adv_len_q, adv_len_d;
    logic              song_done_q, song_done_d;

    logic song_change;
    logic entry_done;
    logic load_en;
    logic restart;

    // Low entry bits carry no information in either entry type.
    logic unused_entry_bits;
    assign unused_entry_bits = ^rom_dout[FIELD_B_LO-1:0];

`ifdef SONG_READER_LOOP_EN
    assign restart = play;
`else
    logic play_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            play_q <= 1'b0;
        end else begin
            play_q <= play;
        end
    end

    assign restart = play && !play_q;
`endif

    // A song change outranks pause and beats; in DONE it restarts the new song.
    assign song_change = (state_q != ST_IDLE) && (song != cur_song_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cur_song_d  = cur_song_q;
        bcnt_d      = bcnt_q;
        adv_len_d   = adv_len_q;
        song_done_d = 1'b0;
        load_en     = 1'b0;
        entry_done  = 1'b0;

        if (song_change) begin
            cur_song_d = song;
            idx_d      = '0;
            bcnt_d     = '0;
            state_d    = ST_FETCH;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (play) begin
                        cur_song_d = song;
                        idx_d      = '0;
                        bcnt_d     = '0;
                        state_d    = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (play) state_d = ST_ROMWAIT;
                end
                ST_ROMWAIT: begin
                    if (play) state_d = ST_DECODE;
                end
                ST_DECODE: begin
                    // Holding DECODE while paused defers the pending load.
                    if (play) begin
                        if (!entry_is_advance(rom_dout)) begin
                            load_en    = 1'b1;
                            entry_done = 1'b1;
                        end else if (entry_field_a(rom_dout) == '0) begin
                            entry_done = 1'b1;
                        end else begin
                            adv_len_d = entry_field_a(rom_dout);
                            bcnt_d    = '0;
                            state_d   = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (play && beat) begin
                        if (bcnt_q == adv_len_q - CNT_ONE) begin
                            entry_done = 1'b1;
                        end else begin
                            bcnt_d = bcnt_q + CNT_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (restart) begin
                        idx_d   = '0;
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Shared completion path for notes, zero-length and expired advances.
            if (entry_done) begin
                if (idx_q == LAST_IDX) begin
                    state_d     = ST_DONE;
                    song_done_d = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = ST_FETCH;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cur_song_q  <= '0;
            bcnt_q      <= '0;
            adv_len_q   <= '0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cur_song_q  <= cur_song_d;
            bcnt_q      <= bcnt_d;
            adv_len_q   <= adv_len_d;
            song_done_q <= song_done_d;
        end
    end

    assign rom_addr  = {cur_song_q, idx_q};
    assign song_done = song_done_q;

    note_dispatch_rr #(
        .NUM_PLAYERS(NUM_PLAYERS)
    ) u_dispatch (
        .clk_i        (clk),
        .rst_i        (reset),
        .load_en_i    (load_en),
        .note_i       (entry_field_a(rom_dout)),
        .dur_i        (entry_field_b(rom_dout)),
        .load_player_o(load_player),
        .note_o       (note_out),
        .dur_o        (duration_out)
    );

endmodule

// File: tb/tb_song_reader.sv
module tb_song_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0;
    logic        beat = 1'b0;
    logic [1:0]  song = 2'd0;
    logic [15:0] rom_dout;
    logic [6:0]  rom_addr;
    logic [5:0]  note_out;
    logic [5:0]  duration_out;
    logic [2:0]  load_player;
    logic        song_done;

    logic [15:0] rom [128];

    int total = 0;
    int bad = 0;

    song_reader dut (
        .clk         (clk),
        .reset       (reset),
        .play        (play),
        .song        (song),
        .beat        (beat),
        .rom_dout    (rom_dout),
        .rom_addr    (rom_addr),
        .note_out    (note_out),
        .duration_out(duration_out),
        .load_player (load_player),
        .song_done   (song_done)
    );

    always #5 clk = ~clk;

    // Synchronous-read song ROM, 1-cycle latency.
    always @(posedge clk) rom_dout <= rom[rom_addr];

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] entry;
        logic [2:0]  exp_load;
        logic [5:0]  exp_note;
        logic [5:0]  exp_dur;
        logic [6:0]  exp_addr;
    } vec_t;

    typedef struct {
        logic [2:0] pl;
        logic [5:0] nt;
        logic [5:0] dr;
    } ld_t;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [15:0] mk_note(input logic [5:0] n, input logic [5:0] d, input logic [2:0] junk);
        return {1'b0, n, d, junk};
    endfunction

    function automatic logic [15:0] mk_adv(input logic [5:0] w, input logic [8:0] junk);
        return {1'b1, w, junk};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fill(input int s, input logic [15:0] e);
        for (int i = 0; i < 32; i++) rom[s*32 + i] = e;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        play  = 1'b0;
        beat  = 1'b0;
        #1;
        check({tag, "_rst_addr"}, rom_addr, 0);
        check({tag, "_rst_load"}, load_player, 0);
        check({tag, "_rst_done"}, song_done, 0);
        check({tag, "_rst_note"}, note_out, 0);
        check({tag, "_rst_dur"}, duration_out, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Each beat is a single-cycle pulse followed by one idle cycle.
    task automatic give_beats(input int n);
        for (int i = 0; i < n; i++) begin
            beat = 1'b1;
            tick();
            beat = 1'b0;
            tick();
        end
    endtask

    task automatic wait_load(input int bound, output int cyc, output logic [2:0] pl,
                             output logic [5:0] nt);
        cyc = 0;
        pl  = '0;
        nt  = '0;
        while (cyc < bound && pl == 3'b000) begin
            tick();
            cyc++;
            if (load_player != 3'b000) begin
                pl = load_player;
                nt = note_out;
            end
        end
    endtask

    vec_t        vecs[8];
    ld_t         expq[$];
    ld_t         e;
    int          cyc, nloads, k;
    logic [2:0]  pl, done_pl;
    logic [5:0]  nt, done_nt;
    logic [6:0]  done_addr;
    logic        done_seen;
    logic [1:0]  s;
    logic [5:0]  rn, rd;

    initial begin
        vecs[0] = '{16'h5187, 3'b001, 6'd40, 6'd48, 7'd1};
        vecs[1] = '{16'h7FFF, 3'b001, 6'd63, 6'd63, 7'd1};
        vecs[2] = '{16'h0000, 3'b001, 6'd0,  6'd0,  7'd1};
        vecs[3] = '{16'h0208, 3'b001, 6'd1,  6'd1,  7'd1};
        vecs[4] = '{16'h81FF, 3'b000, 6'd0,  6'd0,  7'd1};
        vecs[5] = '{16'h8A00, 3'b000, 6'd0,  6'd0,  7'd0};
        vecs[6] = '{16'hFFFF, 3'b000, 6'd0,  6'd0,  7'd0};
        vecs[7] = '{16'h4008, 3'b001, 6'd32, 6'd1,  7'd1};

        for (int i = 0; i < 128; i++) rom[i] = 16'hFE00;
        tick();

        // Entry decode table: one entry at idx 0, observed 4 cycles after play.
        for (int v = 0; v < 8; v++) begin
            do_reset("vec");
            fill(0, 16'hFE00);
            rom[0] = vecs[v].entry;
            song = 2'd0;
            play = 1'b1;
            repeat (4) tick();
            check($sformatf("vec%0d_load", v), load_player, vecs[v].exp_load);
            check($sformatf("vec%0d_note", v), note_out, vecs[v].exp_note);
            check($sformatf("vec%0d_dur", v), duration_out, vecs[v].exp_dur);
            check($sformatf("vec%0d_addr", v), rom_addr, vecs[v].exp_addr);
        end

        // 1: first-note latency.
        do_reset("t1");
        for (int i = 0; i < 32; i++) rom[i] = mk_note(6'(40 + i), 6'd48, 3'd0);
        song = 2'd0;
        play = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            tick();
            if (n == 1) check("t1_addr_fetch", rom_addr, 0);
            if (n < 4) check($sformatf("t1_early_load%0d", n), load_player, 0);
        end
        check("t1_load", load_player, 3'b001);
        check("t1_note", note_out, 40);
        check("t1_dur", duration_out, 48);
        check("t1_addr_next", rom_addr, 1);

        // 2: notes and advances, round-robin players, 12-beat gaps.
        do_reset("t2");
        fill(0, 16'hFE00);
        rom[0] = mk_note(6'd10, 6'd2, 3'd0);
        rom[1] = 16'h9800;
        rom[2] = mk_note(6'd11, 6'd3, 3'd0);
        rom[3] = 16'h9800;
        rom[4] = mk_note(6'd12, 6'd4, 3'd0);
        rom[5] = 16'hE000;
        song = 2'd0;
        play = 1'b1;
        wait_load(8, cyc, pl, nt);
        check("t2_load1_pl", pl, 3'b001);
        check("t2_load1_note", nt, 10);
        repeat (3) tick();
        give_beats(11);
        check("t2_hold_11beats", rom_addr, 1);
        give_beats(1);
        check("t2_adv_12th_beat", rom_addr, 2);
        wait_load(8, cyc, pl, nt);
        check("t2_load2_lat", cyc, 2);
        check("t2_load2_pl", pl, 3'b010);
        check("t2_load2_note", nt, 11);
        repeat (3) tick();
        give_beats(11);
        check("t2_hold2", rom_addr, 3);
        give_beats(1);
        wait_load(8, cyc, pl, nt);
        check("t2_load3_pl", pl, 3'b100);
        check("t2_load3_note", nt, 12);

        // 3: zero-length advance completes without beats.
        do_reset("t3");
        fill(0, 16'hFE00);
        rom[0] = 16'h8000;
        rom[1] = mk_note(6'd20, 6'd5, 3'd0);
        song = 2'd0;
        play = 1'b1;
        repeat (4) tick();
        check("t3_addr_after_adv0", rom_addr, 1);
        check("t3_no_load_yet", load_player, 0);
        repeat (2) tick();
        check("t3_no_load_n6", load_player, 0);
        tick();
        check("t3_load_pl", load_player, 3'b001);
        check("t3_load_note", note_out, 20);

        // 4: pause inside WAIT(12).
        do_reset("t4");
        fill(0, 16'hFE00);
        rom[0] = 16'h9800;
        rom[1] = mk_note(6'd21, 6'd6, 3'd0);
        song = 2'd0;
        play = 1'b1;
        repeat (4) tick();
        give_beats(5);
        play = 1'b0;
        give_beats(20);
        check("t4_paused_addr", rom_addr, 0);
        check("t4_paused_load", load_player, 0);
        play = 1'b1;
        give_beats(6);
        check("t4_resume_hold", rom_addr, 0);
        give_beats(1);
        check("t4_resume_adv", rom_addr, 1);
        wait_load(8, cyc, pl, nt);
        check("t4_load_lat", cyc, 2);
        check("t4_load_pl", pl, 3'b001);
        check("t4_load_note", nt, 21);

        // 5: song change mid-WAIT.
        do_reset("t5");
        fill(0, 16'hFE00);
        fill(2, 16'hFE00);
        rom[0]  = mk_note(6'd22, 6'd1, 3'd0);
        rom[1]  = 16'h9800;
        rom[64] = 16'h8600;
        rom[65] = mk_note(6'd23, 6'd2, 3'd0);
        song = 2'd0;
        play = 1'b1;
        wait_load(8, cyc, pl, nt);
        check("t5_load1_pl", pl, 3'b001);
        repeat (3) tick();
        give_beats(3);
        song = 2'd2;
        tick();
        check("t5_new_addr", rom_addr, 64);
        repeat (3) tick();
        give_beats(2);
        check("t5_bcnt_cleared_hold", rom_addr, 64);
        give_beats(1);
        check("t5_bcnt_cleared_adv", rom_addr, 65);
        wait_load(8, cyc, pl, nt);
        check("t5_load2_pl", pl, 3'b010);
        check("t5_load2_note", nt, 23);

        // 6: end of song.
        do_reset("t6");
        for (int i = 0; i < 32; i++) rom[32 + i] = mk_note(6'(i + 1), 6'(i), 3'd0);
        song = 2'd1;
        play = 1'b1;
        nloads = 0;
        done_seen = 1'b0;
        cyc = 0;
        while (!done_seen && cyc < 200) begin
            tick();
            cyc++;
            if (load_player != 3'b000) nloads++;
            if (song_done) begin
                done_seen = 1'b1;
                done_addr = rom_addr;
                done_pl   = load_player;
                done_nt   = note_out;
            end
        end
        check("t6_done_seen", done_seen, 1);
        check("t6_load_count", nloads, 32);
        check("t6_last_pl", done_pl, 3'b010);
        check("t6_last_note", done_nt, 32);
        check("t6_done_addr", done_addr, 63);
        tick();
        check("t6_done_pulse_width", song_done, 0);
`ifdef SONG_READER_LOOP_EN
        check("t6_loop_addr", rom_addr, 32);
        wait_load(8, cyc, pl, nt);
        check("t6_loop_lat", cyc, 3);
        check("t6_loop_pl", pl, 3'b100);
        check("t6_loop_note", nt, 1);
`else
        check("t6_hold_addr", rom_addr, 63);
        nloads = 0;
        k = 0;
        repeat (20) begin
            tick();
            if (load_player != 3'b000) nloads++;
            if (song_done) k++;
        end
        check("t6_hold_loads", nloads, 0);
        check("t6_hold_done", k, 0);
        check("t6_hold_addr2", rom_addr, 63);
        play = 1'b0;
        tick();
        play = 1'b1;
        tick();
        check("t6_restart_addr", rom_addr, 32);
        wait_load(8, cyc, pl, nt);
        check("t6_restart_lat", cyc, 3);
        check("t6_restart_pl", pl, 3'b100);
        check("t6_restart_note", nt, 1);
`endif

        // Randomized songs with random beats and pauses vs. a load-sequence model.
        for (int run = 0; run < 4; run++) begin
            s = 2'($urandom_range(0, 3));
            expq.delete();
            k = 0;
            for (int i = 0; i < 32; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    rn = 6'($urandom);
                    rd = 6'($urandom);
                    rom[s*32 + i] = mk_note(rn, rd, 3'($urandom));
                    e.pl = 3'(1 << (k % 3));
                    e.nt = rn;
                    e.dr = rd;
                    expq.push_back(e);
                    k++;
                end else begin
                    rom[s*32 + i] = mk_adv(6'($urandom_range(0, 3)), 9'($urandom));
                end
            end
            do_reset("rand");
            song = s;
            play = 1'b1;
            done_seen = 1'b0;
            cyc = 0;
            while (!done_seen && cyc < 2000) begin
                tick();
                cyc++;
                if (load_player != 3'b000) begin
                    if (expq.size() == 0) begin
                        check("rand_extra_load", load_player, 0);
                    end else begin
                        e = expq.pop_front();
                        check("rand_player", load_player, e.pl);
                        check("rand_note", note_out, e.nt);
                        check("rand_dur", duration_out, e.dr);
                    end
                end
                if (song_done) begin
                    check("rand_loads_left_at_done", expq.size(), 0);
                    done_seen = 1'b1;
                end
                beat = ($urandom_range(0, 2) == 0);
                play = ($urandom_range(0, 7) != 0);
            end
            check("rand_song_done", done_seen, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
